sdram_test_sequencer: RTL and testbench
=======================================

Name: sdram_test_sequencer

Overview:
Self-checking SDRAM exerciser for the EG4S20 SDRAM test system. On a start pulse it writes a deterministic pattern over a word address range through the SDRAM controller's request interface. It then reads the range back with a bounded number of outstanding reads and compares every returned word. It reports busy/done/pass, a saturating error count and the first failing address, for LEDs or a waveform check in the system bench.

Parameters:
ADDR_W, 21, word address width of the controller request port
DATA_W, 32, data width
START_ADDR, 0, first word address tested
END_ADDR, 1023, last word address tested, inclusive; must be >= START_ADDR
SEED, 32'hA5A5_5A5A, pattern seed (DATA_W bits)
MAX_OUT, 4, maximum reads in flight (1..15)

Ports:
clk_in  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle start pulse; honoured only when busy=0
cmd_req  out  1  command request to the SDRAM controller
cmd_wr  out  1  1=write, 0=read; valid while cmd_req=1
cmd_addr  out  ADDR_W  command word address
cmd_wdata  out  DATA_W  write data
cmd_ack  in  1  command accepted on a cycle where cmd_req && cmd_ack
rd_valid  in  1  read data valid; returns in issue order, any latency >= 1
rd_data  in  DATA_W  read data
busy  out  1  test in progress
done  out  1  test finished; level, held until next start
pass  out  1  valid when done=1; 1 = zero mismatches
err_cnt  out  16  mismatch count, saturates at 16'hFFFF
first_err_addr  out  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal counters 0.
- pattern(a) = SEED XOR a (a zero-extended or truncated to DATA_W).
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE + start: clear done, pass, err_cnt and first_err_addr; set issue addr = START_ADDR; busy=1; go to WRITE on the next edge.
- start while busy=1: ignored.
- Request rule: once cmd_req=1, cmd_wr, cmd_addr and cmd_wdata stay stable until accepted. There is no withdrawal of a request.
- WRITE: cmd_req=1, cmd_wr=1, cmd_wdata=pattern(cmd_addr).
  - On accept with addr != END_ADDR: increment addr, keep cmd_req high (back-to-back writes allowed).
  - On accept with addr == END_ADDR: cmd_req=0 for one cycle, reset issue and check addresses to START_ADDR, go to READ.
- READ: cmd_req=1, cmd_wr=0 while outstanding < MAX_OUT.
  - Accepted read: outstanding+1. rd_valid: outstanding-1. Both in one cycle: unchanged.
  - Outstanding never exceeds MAX_OUT. cmd_req drops registered, so it must already be 0 in the cycle outstanding would reach MAX_OUT+1.
  - Accept of END_ADDR: cmd_req=0, go to DRAIN.
- Check (READ and DRAIN): on rd_valid, compare rd_data with pattern(check addr), then increment check addr.
  - Mismatch: err_cnt+1, saturating.
  - First mismatch (err_cnt==0 before the increment): capture first_err_addr.
- DRAIN: when the END_ADDR word has been checked (outstanding reaches 0), go to DONE. Set busy=0, done=1, pass=(err_cnt==0), all in the same edge.
- rd_valid in IDLE, WRITE or DONE: ignored, no count change.
- Outputs update on the clock edge after the causing event, except the async reset clear.
- START_ADDR == END_ADDR: one write, one read; legal.
- Reset mid-operation: immediate return to reset values. In-flight reads are discarded; the controller must be reset with the same rst.

Test Plan:
1. Assert rst for 2 cycles mid-idle -> cmd_req=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0 while rst=1.
2. START_ADDR=0, END_ADDR=15, ideal memory model (ack same cycle, read latency 3), start pulse -> exactly 16 writes with addr 0..15 and wdata=A5A5_5A5A^addr, then 16 reads; done=1, pass=1, err_cnt=0, busy=0.
3. Same setup, model flips bit 0 of word 5 on read -> err_cnt=1, first_err_addr=5, pass=0, done=1.
4. Model holds cmd_ack low 10 cycles per command and delays rd_valid 20 cycles -> cmd_addr/cmd_wdata/cmd_wr stable while waiting; outstanding monitor never exceeds 4; result pass=1.
5. Start pulse while busy -> ignored; no restart. Start after done with a fault-free model, following scenario 3 -> err_cnt back to 0, done cleared within 1 cycle, final pass=1.
6. Assert rst during READ with 3 reads outstanding, then release and start again -> all outputs 0 during rst; second run completes pass=1 with exactly 16 reads checked.

Source files
------------

// File: rtl/sdram_test_sequencer.sv
// SDRAM exerciser: writes SEED^addr over [START_ADDR..END_ADDR] through the
// controller request port, reads the range back with at most MAX_OUT reads in
// flight, and compares every returned word against the same pattern.
//
// Handshake: a command transfers on a rising edge where cmd_req && cmd_ack.
// Once cmd_req is high, cmd_wr/cmd_addr/cmd_wdata hold until that transfer;
// a request is never withdrawn. Read data returns in issue order, one word per
// cycle with rd_valid, any latency >= 1.
module sdram_test_sequencer #(
   parameter int                ADDR_W     = 21,
   parameter int                DATA_W     = 32,
   parameter int                START_ADDR = 0,
   parameter int                END_ADDR   = 1023,
   parameter logic [DATA_W-1:0] SEED       = DATA_W'(32'hA5A5_5A5A),
   parameter int                MAX_OUT    = 4
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              start,
   output logic              cmd_req,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [DATA_W-1:0] cmd_wdata,
   input  logic              cmd_ack,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [2:0]        dbg_state
);

   localparam int                OUT_W   = 4;
   localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
   localparam logic [OUT_W-1:0]  MAX_O   = OUT_W'(MAX_OUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [ADDR_W-1:0]   chk_q, chk_d;
   logic [OUT_W-1:0]    out_q, out_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [15:0]         err_q, err_d;
   logic [ADDR_W-1:0]   ferr_q, ferr_d;

   logic                accept;
   logic                chk_en;
   logic                rd_inc;

   // Address is zero-extended or truncated to the data width.
   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      return SEED ^ DATA_W'(a);
   endfunction

   // Next-state logic: command issue, read-back checking and test sequencing.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      chk_d   = chk_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      ferr_d  = ferr_q;

      accept = req_q && cmd_ack;
      chk_en = rd_valid && ((state_q == S_READ) || (state_q == S_DRAIN));
      rd_inc = accept && (state_q == S_READ);

      // Read returns are only meaningful while the read phase is live.
      if (chk_en) begin
         chk_d = chk_q + 1'b1;
         if (rd_data != pattern(chk_q)) begin
            if (err_q != 16'hFFFF) begin
               err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
               ferr_d = chk_q;
            end
         end
      end

      out_d = out_q + {{(OUT_W-1){1'b0}}, rd_inc} - {{(OUT_W-1){1'b0}}, chk_en};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_WRITE;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = 16'd0;
               ferr_d  = '0;
               addr_d  = START_A;
               chk_d   = START_A;
               out_d   = '0;
               req_d   = 1'b1;
               wr_d    = 1'b1;
               wdata_d = pattern(START_A);
            end
         end

         S_WRITE: begin
            if (accept) begin
               if (addr_q == END_A) begin
                  // One idle request cycle separates the write and read phases.
                  state_d = S_READ;
                  req_d   = 1'b0;
                  wr_d    = 1'b0;
                  wdata_d = '0;
                  addr_d  = START_A;
                  chk_d   = START_A;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  wdata_d = pattern(addr_q + 1'b1);
               end
            end
         end

         S_READ: begin
            if (accept && (addr_q == END_A)) begin
               state_d = S_DRAIN;
               req_d   = 1'b0;
            end else begin
               if (accept) begin
                  addr_d = addr_q + 1'b1;
               end
               // cmd_req is registered, so it must already be low in any cycle
               // where one more accept would exceed the in-flight limit. A held
               // request always satisfies this because out_d <= out_q then.
               req_d = (out_d < MAX_O);
            end
         end

         S_DRAIN: begin
            if (out_d == '0) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == 16'd0);
            end
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Sequencer state and all registered outputs.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         chk_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 16'd0;
         ferr_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         chk_q   <= chk_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
      end
   end

   assign cmd_req        = req_q;
   assign cmd_wr         = wr_q;
   assign cmd_addr       = addr_q;
   assign cmd_wdata      = wdata_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_q;
   assign first_err_addr = ferr_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_sdram_test_sequencer.sv
// Bench for sdram_test_sequencer over a 16-word range with a small SDRAM
// controller model (configurable accept delay, read latency, bit fault).
module tb_sdram_test_sequencer;

   localparam int          ADDR_W  = 21;
   localparam int          DATA_W  = 32;
   localparam int          END_A   = 15;
   localparam int          MAXO    = 4;
   localparam logic [31:0] SEED    = 32'hA5A5_5A5A;
   localparam logic [2:0]  ST_READ = 3'd2;

   logic              clk_in = 1'b0;
   logic              rst    = 1'b1;
   logic              start  = 1'b0;
   logic              cmd_req;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              cmd_ack  = 1'b0;
   logic              rd_valid = 1'b0;
   logic [DATA_W-1:0] rd_data  = '0;
   logic              busy;
   logic              done;
   logic              pass;
   logic [15:0]       err_cnt;
   logic [ADDR_W-1:0] first_err_addr;
   logic [2:0]        dbg_state;

   sdram_test_sequencer #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .START_ADDR(0),
      .END_ADDR  (END_A),
      .SEED      (SEED),
      .MAX_OUT   (MAXO)
   ) dut (
      .clk_in        (clk_in),
      .rst           (rst),
      .start         (start),
      .cmd_req       (cmd_req),
      .cmd_wr        (cmd_wr),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_ack       (cmd_ack),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_cnt       (err_cnt),
      .first_err_addr(first_err_addr),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- controller model ----------------
   int                ack_wait  = 0;
   int                rd_lat    = 3;
   bit                flip_en   = 1'b0;
   int                wait_cnt  = 0;
   int                cyc       = 0;
   int                wr_cnt    = 0;
   int                rd_iss    = 0;
   int                rd_ret    = 0;
   int                outst     = 0;
   int                max_outst = 0;
   logic [DATA_W-1:0] mem [0:15];
   int                due_q[$];
   logic [ADDR_W-1:0] rd_addr_q[$];
   logic [ADDR_W-1:0] wr_exp_q[$];
   logic [ADDR_W-1:0] rd_exp_q[$];
   logic              held_v     = 1'b0;
   logic              held_wr    = 1'b0;
   logic [ADDR_W-1:0] held_addr  = '0;
   logic [DATA_W-1:0] held_wdata = '0;
   logic [ADDR_W-1:0] e_addr;
   logic [ADDR_W-1:0] nb_addr;

   // Sample the handshake at the active edge (DUT outputs still pre-update).
   always @(posedge clk_in) begin
      if (rst) begin
         due_q.delete();
         rd_addr_q.delete();
         outst    = 0;
         held_v   = 1'b0;
         wait_cnt = 0;
      end else begin
         cyc++;
         if (held_v) begin
            check_eq("hold_req",   cmd_req,   1'b1);
            check_eq("hold_wr",    cmd_wr,    held_wr);
            check_eq("hold_addr",  cmd_addr,  held_addr);
            check_eq("hold_wdata", cmd_wdata, held_wdata);
         end
         held_v     = cmd_req && !cmd_ack;
         held_wr    = cmd_wr;
         held_addr  = cmd_addr;
         held_wdata = cmd_wdata;
         if (cmd_req && cmd_ack) begin
            wait_cnt = 0;
            if (cmd_wr) begin
               wr_cnt++;
               mem[cmd_addr[3:0]] = cmd_wdata;
               if (wr_exp_q.size() > 0) begin
                  e_addr = wr_exp_q.pop_front();
                  check_eq("wr_addr",  cmd_addr,  e_addr);
                  check_eq("wr_wdata", cmd_wdata, SEED ^ 32'(e_addr));
               end
            end else begin
               rd_iss++;
               outst++;
               rd_addr_q.push_back(cmd_addr);
               due_q.push_back(cyc + rd_lat);
               if (rd_exp_q.size() > 0) begin
                  e_addr = rd_exp_q.pop_front();
                  check_eq("rd_addr", cmd_addr, e_addr);
               end
            end
         end
         if (rd_valid) begin
            rd_ret++;
            outst--;
         end
         if (outst > max_outst) max_outst = outst;
      end
   end

   // Drive the controller responses mid-cycle.
   always @(negedge clk_in) begin
      if (rst) begin
         cmd_ack  = 1'b0;
         rd_valid = 1'b0;
         rd_data  = '0;
         due_q.delete();
         rd_addr_q.delete();
      end else begin
         cmd_ack = 1'b0;
         if (cmd_req) begin
            if (wait_cnt >= ack_wait) cmd_ack = 1'b1;
            else wait_cnt++;
         end
         rd_valid = 1'b0;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            nb_addr = rd_addr_q.pop_front();
            void'(due_q.pop_front());
            rd_valid = 1'b1;
            rd_data  = mem[nb_addr[3:0]] ^ {31'b0, (flip_en && nb_addr == 5)};
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_test(input int aw, input int lat, input bit flip);
      ack_wait = aw;
      rd_lat   = lat;
      flip_en  = flip;
      wr_exp_q.delete();
      rd_exp_q.delete();
      for (int i = 0; i <= END_A; i++) begin
         wr_exp_q.push_back(ADDR_W'(i));
         rd_exp_q.push_back(ADDR_W'(i));
      end
      wr_cnt    = 0;
      rd_iss    = 0;
      rd_ret    = 0;
      max_outst = 0;
      pulse_start();
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, done, 1'b1);
   endtask

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_req"},   cmd_req,        1'b0);
      check_eq({tag, "_busy"},  busy,           1'b0);
      check_eq({tag, "_done"},  done,           1'b0);
      check_eq({tag, "_pass"},  pass,           1'b0);
      check_eq({tag, "_err"},   err_cnt,        16'd0);
      check_eq({tag, "_ferr"},  first_err_addr, 21'd0);
      check_eq({tag, "_addr"},  cmd_addr,       21'd0);
      check_eq({tag, "_state"}, dbg_state,      3'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      // 1: reset values while rst is held
      rst = 1'b1;
      tick();
      tick();
      check_idle_zero("rst");
      rst = 1'b0;
      tick();
      check_idle_zero("idle");

      // 2: clean run, immediate accept, read latency 3
      run_test(0, 3, 1'b0);
      check_eq("s2_busy_after_start", busy, 1'b1);
      check_eq("s2_req_after_start",  cmd_req, 1'b1);
      check_eq("s2_wr_after_start",   cmd_wr, 1'b1);
      check_eq("s2_wdata0",           cmd_wdata, 32'hA5A5_5A5A);
      wait_done("s2_done", 500);
      check_eq("s2_pass",   pass, 1'b1);
      check_eq("s2_err",    err_cnt, 16'd0);
      check_eq("s2_busy",   busy, 1'b0);
      check_eq("s2_ferr",   first_err_addr, 21'd0);
      check_eq("s2_writes", wr_cnt, 16);
      check_eq("s2_reads",  rd_iss, 16);
      check_eq("s2_rets",   rd_ret, 16);
      check_eq("s2_mem5",   mem[5], 32'hA5A5_5A5F);
      check_eq("s2_mem15",  mem[15], 32'hA5A5_5A55);
      tick();
      check_eq("s2_req_idle", cmd_req, 1'b0);

      // 3: bit 0 of word 5 flipped on read
      run_test(0, 3, 1'b1);
      wait_done("s3_done", 500);
      check_eq("s3_err",  err_cnt, 16'd1);
      check_eq("s3_ferr", first_err_addr, 21'd5);
      check_eq("s3_pass", pass, 1'b0);

      // 5: restart after done clears status; start while busy is ignored
      run_test(0, 3, 1'b0);
      check_eq("s5_done_cleared", done, 1'b0);
      check_eq("s5_err_cleared",  err_cnt, 16'd0);
      check_eq("s5_ferr_cleared", first_err_addr, 21'd0);
      check_eq("s5_busy",         busy, 1'b1);
      tick();
      tick();
      pulse_start();
      check_eq("s5_busy_kept", busy, 1'b1);
      wait_done("s5_done", 500);
      check_eq("s5_pass",   pass, 1'b1);
      check_eq("s5_err",    err_cnt, 16'd0);
      check_eq("s5_writes", wr_cnt, 16);
      check_eq("s5_reads",  rd_iss, 16);

      // 4: slow accept (10 cycles) and read latency 20
      run_test(10, 20, 1'b0);
      wait_done("s4_done", 3000);
      check_eq("s4_pass",   pass, 1'b1);
      check_eq("s4_outmax", (max_outst <= MAXO), 1'b1);
      check_eq("s4_writes", wr_cnt, 16);
      check_eq("s4_rets",   rd_ret, 16);

      // 6: reset during READ with 3 reads outstanding, then rerun
      run_test(0, 20, 1'b0);
      n = 0;
      while (!(dbg_state == ST_READ && outst == 3) && n < 500) begin
         tick();
         n++;
      end
      check_eq("s6_reach_out3", outst, 3);
      rst = 1'b1;
      #1;
      check_idle_zero("s6_rst_async");
      tick();
      check_idle_zero("s6_rst");
      tick();
      rst = 1'b0;
      tick();
      run_test(0, 20, 1'b0);
      wait_done("s6_done", 1000);
      check_eq("s6_pass",   pass, 1'b1);
      check_eq("s6_err",    err_cnt, 16'd0);
      check_eq("s6_rets",   rd_ret, 16);
      check_eq("s6_reads",  rd_iss, 16);
      check_eq("s6_outmax", max_outst, MAXO);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
